// File: rtl/cpu_io_peripheral.sv
// Port-side I/O peripheral: input byte FIFO with interrupt pulse toward the CPU, output latch toward a consumer.
// Optional interrupt FSM built only when CPU_IO_PERIPH_INT_EN is defined; otherwise int_sig is tied low.
module cpu_io_peripheral #(
    parameter int DEPTH     = 4,
    parameter int INT_PULSE = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 src_data,
    input  logic                       src_valid,
    output logic                       src_ready,
    output logic [7:0]                 I_Port,
    input  logic                       in_rd,
    output logic                       int_sig,
    input  logic [7:0]                 O_Port,
    input  logic                       out_wr,
    output logic [7:0]                 dst_data,
    output logic                       dst_valid,
    input  logic                       dst_ready,
    output logic [$clog2(DEPTH):0]     in_count,
    output logic                       ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign push      = src_valid && !full;
    assign pop       = in_rd && !empty;
    assign src_ready = !full;
    assign in_count  = count;
    assign I_Port    = empty ? 8'h00 : mem[rd_ptr];

    // Storage needs no reset: the head is masked by empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= src_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef CPU_IO_PERIPH_INT_EN
    typedef enum logic [1:0] {IDLE, PULSE, WAIT} int_state_t;

    int_state_t state;
    logic [3:0] pulse_cnt;
    logic       int_q;

    // Only an empty -> non-empty transition interrupts; WAIT absorbs further pushes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pulse_cnt <= '0;
            int_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        state     <= PULSE;
                        pulse_cnt <= 4'd1;
                        int_q     <= 1'b1;
                    end
                end
                PULSE: begin
                    if (pulse_cnt == 4'(INT_PULSE)) begin
                        int_q <= 1'b0;
                        state <= empty ? IDLE : WAIT;
                    end else begin
                        pulse_cnt <= pulse_cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (empty) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    int_q <= 1'b0;
                end
            endcase
        end
    end

    assign int_sig = int_q;
`else
    assign int_sig = 1'b0;
`endif

    // A write into an unaccepted byte is dropped and flagged; a same-cycle accept frees the slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dst_data  <= 8'h00;
            dst_valid <= 1'b0;
            ovf       <= 1'b0;
        end else if (out_wr) begin
            if (!dst_valid) begin
                dst_data  <= O_Port;
                dst_valid <= 1'b1;
            end else if (dst_ready) begin
                dst_data <= O_Port;
            end else begin
                ovf <= 1'b1;
            end
        end else if (dst_valid && dst_ready) begin
            dst_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cpu_io_peripheral.sv
// Directed plus randomized bench for cpu_io_peripheral against a queue-based reference model.
module tb_cpu_io_peripheral;
    localparam int DEPTH     = 4;
    localparam int INT_PULSE = 2;
`ifdef CPU_IO_PERIPH_INT_EN
    localparam bit INT_EN = 1'b1;
`else
    localparam bit INT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] src_data = '0;
    logic       src_valid = 1'b0;
    logic       src_ready;
    logic [7:0] I_Port;
    logic       in_rd = 1'b0;
    logic       int_sig;
    logic [7:0] O_Port = '0;
    logic       out_wr = 1'b0;
    logic [7:0] dst_data;
    logic       dst_valid;
    logic       dst_ready = 1'b0;
    logic [2:0] in_count;
    logic       ovf;

    int checks = 0;
    int failures = 0;

    // Reference state
    logic [7:0] q[$];
    bit         armed;      // no interrupt outstanding: next arrival interrupts
    int         int_left;   // cycles of int_sig still to be high
    logic [7:0] m_dd;
    bit         m_dv;
    bit         m_ovf;

    cpu_io_peripheral #(.DEPTH(DEPTH), .INT_PULSE(INT_PULSE)) dut (
        .clk(clk), .rst(rst),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .I_Port(I_Port), .in_rd(in_rd), .int_sig(int_sig),
        .O_Port(O_Port), .out_wr(out_wr),
        .dst_data(dst_data), .dst_valid(dst_valid), .dst_ready(dst_ready),
        .in_count(in_count), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%02h exp=%02h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        armed    = 1'b1;
        int_left = 0;
        m_dd     = 8'h00;
        m_dv     = 1'b0;
        m_ovf    = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".I_Port"},    I_Port,              (q.size() > 0) ? q[0] : 8'h00);
        chk({tag, ".in_count"},  8'(in_count),        8'(q.size()));
        chk({tag, ".src_ready"}, 8'(src_ready),       8'(q.size() < DEPTH));
        chk({tag, ".int_sig"},   8'(int_sig),         8'(INT_EN && int_left > 0));
        chk({tag, ".dst_data"},  dst_data,            m_dd);
        chk({tag, ".dst_valid"}, 8'(dst_valid),       8'(m_dv));
        chk({tag, ".ovf"},       8'(ovf),             8'(m_ovf));
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare.
    task automatic tick(input string tag);
        int occ;
        @(posedge clk);
        occ = q.size();
        if (int_left > 0) begin
            int_left--;
            if (int_left == 0) armed = (occ == 0);
        end else if (armed) begin
            if (occ > 0) begin
                armed    = 1'b0;
                int_left = INT_PULSE;
            end
        end else if (occ == 0) begin
            armed = 1'b1;
        end
        if (in_rd && occ > 0) void'(q.pop_front());
        if (src_valid && occ < DEPTH) q.push_back(src_data);
        if (out_wr) begin
            if (!m_dv) begin
                m_dd = O_Port;
                m_dv = 1'b1;
            end else if (dst_ready) begin
                m_dd = O_Port;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (m_dv && dst_ready) begin
            m_dv = 1'b0;
        end
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        src_valid = 1'b0;
        in_rd     = 1'b0;
        out_wr    = 1'b0;
        dst_ready = 1'b0;
    endtask

    task automatic async_reset(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Single push with CPU idle: data visible next cycle, interrupt pulse follows
        src_data = 8'hA5; src_valid = 1'b1;
        tick("push_a5");
        chk("push_a5.I_Port_const", I_Port, 8'hA5);
        src_valid = 1'b0;
        repeat (4) tick("a5_pulse");
        in_rd = 1'b1; tick("pop_a5");
        in_rd = 1'b0; tick("after_pop_a5");
        in_rd = 1'b1; tick("pop_empty");
        in_rd = 1'b0;

        // Fill to full, attempt an overflow push, then drain
        for (int i = 1; i <= 5; i++) begin
            src_data = 8'(i); src_valid = 1'b1;
            tick("fill1");
        end
        chk("full.src_ready_const", 8'(src_ready), 8'h00);
        src_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_rd = 1'b1; tick("drain1");
            in_rd = 1'b0; tick("drain1_gap");
        end

        // Second fill exercises pointer wrap
        for (int i = 5; i <= 8; i++) begin
            src_data = 8'(i); src_valid = 1'b1;
            tick("fill2");
        end
        // Full: push attempt with simultaneous pop
        src_data = 8'hEE; src_valid = 1'b1; in_rd = 1'b1;
        tick("full_push_pop");
        chk("full_push_pop.count_const", 8'(in_count), 8'd3);
        src_valid = 1'b0;
        tick("pop_to_two");
        // Half full: push and pop together
        src_data = 8'h99; src_valid = 1'b1; in_rd = 1'b1;
        tick("half_push_pop");
        chk("half_push_pop.count_const", 8'(in_count), 8'd2);
        src_valid = 1'b0; in_rd = 1'b1;
        repeat (3) tick("drain2");
        in_rd = 1'b0;

        // Output latch: drop on stall, then accept
        O_Port = 8'h3C; out_wr = 1'b1; dst_ready = 1'b0;
        tick("wr_3c");
        O_Port = 8'h77;
        tick("wr_77_drop");
        chk("wr_77_drop.dst_data_const", dst_data, 8'h3C);
        chk("wr_77_drop.ovf_const", 8'(ovf), 8'h01);
        out_wr = 1'b0; dst_ready = 1'b1;
        tick("accept");
        dst_ready = 1'b0;
        tick("accept_idle");

        // Fresh reset clears ovf; then send-and-capture in one cycle
        async_reset("rst_ovf");
        O_Port = 8'h11; out_wr = 1'b1;
        tick("wr_11");
        O_Port = 8'h22; dst_ready = 1'b1;
        tick("wr_22_pass");
        chk("wr_22_pass.dst_data_const", dst_data, 8'h22);
        idle_inputs();
        tick("wr_22_idle");

        // Reset during the interrupt pulse with three bytes queued
        for (int i = 0; i < 3; i++) begin
            src_data = 8'hB0 + 8'(i); src_valid = 1'b1;
            tick("queue3");
        end
        src_valid = 1'b0;
        async_reset("rst_mid_pulse");
        chk("rst_mid_pulse.I_Port_const", I_Port, 8'h00);
        tick("post_rst");

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            src_valid = ($urandom_range(0, 2) != 0);
            src_data  = 8'($urandom);
            in_rd     = ($urandom_range(0, 2) == 0);
            out_wr    = ($urandom_range(0, 2) == 0);
            O_Port    = 8'($urandom);
            dst_ready = ($urandom_range(0, 1) == 1);
            if (n == 200) async_reset("rand_rst");
            tick("rand");
        end
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cpu_io_peripheral.md
# cpu_io_peripheral

I/O peripheral that sits on the far side of the CPU's port interface. It drives the CPU's 8-bit input port and interrupt line, and it consumes the CPU's 8-bit output port. Bytes from an external producer are buffered in a small FIFO and presented to the CPU. When new data arrives, the CPU is interrupted. Bytes written by the CPU are latched and handed to an external consumer over a valid/ready handshake.

## Interface
Parameters:
- DEPTH, 4, input FIFO depth in entries; power of two, 2..16.
- INT_PULSE, 2, width of the int_sig pulse in cycles; 1..15.

Ports:
- clk  in  1  single system clock; all logic is rising-edge.
- rst  in  1  reset; asynchronous, active-high.
- src_data  in  8  byte from the external producer.
- src_valid  in  1  producer has a byte.
- src_ready  out  1  FIFO can accept; equals !full.
- I_Port  out  8  CPU input port; FIFO head, or 0x00 when empty.
- in_rd  in  1  one-cycle strobe: CPU executed IN and consumed I_Port.
- int_sig  out  1  interrupt request to the CPU.
- O_Port  in  8  CPU output port data.
- out_wr  in  1  one-cycle strobe: CPU executed OUT and O_Port is valid.
- dst_data  out  8  byte to the external consumer.
- dst_valid  out  1  dst_data holds an unsent byte.
- dst_ready  in  1  consumer accepts.
- in_count  out  log2(DEPTH)+1  current FIFO occupancy.
- ovf  out  1  sticky flag: a CPU write was dropped.

## Operation
Input FIFO:
- Push when src_valid && src_ready.
- Pop when in_rd && !empty. An in_rd while empty is ignored and leaves the state unchanged.
- A simultaneous push and pop on a full FIFO is legal. src_ready is low when full, so only the pop takes effect.
- A simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. full/empty come from in_count.
- I_Port is combinational from the head entry, qualified by !empty.

Interrupt FSM, states IDLE, PULSE, WAIT:
- IDLE -> PULSE on the cycle after the FIFO goes empty -> non-empty. int_sig=1 in PULSE.
- PULSE counts INT_PULSE cycles, then -> WAIT.
- WAIT -> IDLE when the FIFO is empty again. Further pushes while non-empty do not re-interrupt.
- If the FIFO drains during PULSE, the pulse still completes, then -> IDLE directly.

Output register:
- out_wr with !dst_valid: capture O_Port into dst_data and set dst_valid.
- out_wr with dst_valid && dst_ready on the same cycle: the old byte is sent and the new byte is captured. dst_valid stays 1.
- out_wr with dst_valid && !dst_ready: the new byte is dropped, ovf is set, and dst_data is unchanged.
- dst_valid && dst_ready without out_wr: clear dst_valid.
- ovf clears only on rst.

## Timing
- Reset values: src_ready=1, I_Port=0x00, int_sig=0, dst_data=0x00, dst_valid=0, in_count=0, ovf=0. The FSM resets to IDLE and the FIFO is empty.
- Push-to-I_Port latency: one cycle. A byte pushed at edge N is visible on I_Port after edge N when the FIFO was empty.
- Push-to-int_sig latency: int_sig rises one cycle after the push edge and stays high for exactly INT_PULSE cycles.
- A pop at edge N presents the next entry, or 0x00, after edge N.
- out_wr-to-dst_valid latency: one cycle. dst_data/dst_valid are registered and stable until accepted.
- rst mid-operation discards FIFO contents, any pending output byte, and an in-progress pulse immediately (asynchronous).

## Configuration
- CPU_IO_PERIPH_INT_EN defined: the interrupt FSM is built and int_sig behaves as specified.
- CPU_IO_PERIPH_INT_EN undefined: the FSM is omitted and int_sig is tied to 0. The CPU polls I_Port/in_count instead. All other behaviour is identical.

## Test plan
- Reset, then push 0xA5 with in_rd idle -> I_Port=0xA5 next cycle, in_count=1, int_sig high for 2 cycles starting one cycle after the push, FSM in WAIT.
- Push 0x01..0x04 (DEPTH=4), then assert src_valid again -> src_ready=0 and the fifth byte is not taken. Four in_rd strobes -> I_Port reads 0x01, 0x02, 0x03, 0x04, then 0x00; wrap verified by a second fill of 0x05..0x08.
- Full FIFO with a simultaneous push attempt and in_rd -> count 3, head advances, pushed byte absent. Half-full FIFO with push and pop -> count unchanged.
- out_wr O_Port=0x3C with dst_ready=0, then out_wr 0x77 -> dst_data stays 0x3C and ovf=1. Raise dst_ready -> dst_valid clears after one cycle.
- dst_valid=1 holding 0x11, dst_ready=1 and out_wr 0x22 on the same cycle -> dst_data=0x22, dst_valid=1, ovf=0.
- Assert rst during the int_sig pulse with 3 bytes queued -> int_sig=0, in_count=0, I_Port=0x00 immediately. With CPU_IO_PERIPH_INT_EN undefined, repeat the first scenario -> int_sig stays 0.
